// File: rtl/flash_word_fetcher.sv
// flash_word_fetcher: turns (address, word count) requests into flash_reader byte streams,
// packs bytes little-endian into 32-bit words and buffers them in a small output FIFO.
module flash_word_fetcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [23:0]        req_addr,
    input  logic [COUNT_W-1:0] req_words,
    input  logic               abort,
    output logic [31:0]        word_data,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               busy,
    output logic [23:0]        fr_addr,
    output logic               fr_start_read,
    output logic               fr_keep_reading,
    input  logic [7:0]         fr_data,
    input  logic               fr_data_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, STREAM, PAUSE} state_t;

    state_t state, state_nx;
    logic [23:0] next_addr, next_addr_nx;
    logic [COUNT_W-1:0] remaining;
    logic [1:0] idx;
    logic [23:0] asm_word;
    logic [31:0] slots [FIFO_DEPTH];
    logic [CW-1:0] count, count_nx, wr_idx;
    logic accept, byte_in, push, pop, last_word;

    assign req_ready = state == IDLE && !abort;
    assign accept = req_valid && req_ready;
    assign byte_in = state == STREAM && fr_data_ready;
    assign push = byte_in && idx == 2'd3 && !abort;
    assign pop = word_valid && word_ready;
    assign last_word = remaining == COUNT_W'(1);
    assign wr_idx = count - CW'(pop);
    assign count_nx = abort ? '0 : count + CW'(push) - CW'(pop);
    assign next_addr_nx = accept ? (req_addr & 24'hFFFFFC) : push ? next_addr + 24'd4 : next_addr;
    assign word_data = slots[0];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && req_words != '0) state_nx = START;
            START:   state_nx = STREAM;
            STREAM:  if (push) state_nx = last_word ? IDLE : (count_nx == CW'(FIFO_DEPTH)) ? PAUSE : STREAM;
            PAUSE:   if (count <= CW'(FIFO_DEPTH - 2)) state_nx = START;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            fr_start_read   <= 1'b0;
            fr_keep_reading <= 1'b0;
            fr_addr         <= '0;
            next_addr       <= '0;
            remaining       <= '0;
            idx             <= '0;
            asm_word        <= '0;
            count           <= '0;
            word_valid      <= 1'b0;
        end else begin
            state           <= state_nx;
            busy            <= state_nx != IDLE;
            fr_start_read   <= state_nx == START;
            fr_keep_reading <= state_nx == STREAM;
            if (state_nx == START) fr_addr <= next_addr_nx;
            next_addr       <= next_addr_nx;
            remaining       <= abort ? '0 : accept ? req_words : push ? remaining - COUNT_W'(1) : remaining;
            // Bytes shift in from the top so the first byte ends up in [7:0]
            if (abort || state == START) begin
                idx      <= '0;
                asm_word <= '0;
            end else if (byte_in) begin
                idx      <= idx + 2'd1;
                asm_word <= {fr_data, asm_word[23:8]};
            end
            count           <= count_nx;
            word_valid      <= count_nx != '0;
        end
    end

    // Shift-register FIFO: slot 0 is the head, so word_data comes straight from a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) slots[i] <= '0;
        end else if (abort) begin
            for (int i = 0; i < FIFO_DEPTH; i++) slots[i] <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (push && i == int'(wr_idx)) slots[i] <= {fr_data, asm_word};
                else if (pop) slots[i] <= (i == FIFO_DEPTH - 1) ? '0 : slots[(i + 1) % FIFO_DEPTH];
            end
        end
    end
endmodule

// File: tb/tb_flash_word_fetcher.sv
// tb_flash_word_fetcher: random and directed requests against a byte-stream flash model,
// with a word scoreboard and FIFO occupancy model derived from accepted bytes.
module tb_flash_word_fetcher;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready, abort, word_valid, word_ready, busy;
    logic [23:0] req_addr, fr_addr;
    logic [15:0] req_words;
    logic [31:0] word_data;
    logic fr_start_read, fr_keep_reading, fr_data_ready;
    logic [7:0] fr_data;

    always #5 clk = ~clk;

    flash_word_fetcher #(.FIFO_DEPTH(DEPTH), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_words(req_words), .abort(abort),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .busy(busy), .fr_addr(fr_addr), .fr_start_read(fr_start_read),
        .fr_keep_reading(fr_keep_reading), .fr_data(fr_data), .fr_data_ready(fr_data_ready)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [23:0] a);
        return a[23:16] ^ a[15:8] ^ a[7:0];
    endfunction

    function automatic logic [31:0] word_at(input logic [23:0] a);
        return {pat(a + 24'd3), pat(a + 24'd2), pat(a + 24'd1), pat(a)};
    endfunction

    logic [31:0] expq[$];
    logic [31:0] got_q[$];
    int occ = 0, bc = 0, starts = 0, max_occ = 0;
    logic [23:0] exp_next = '0, last_start = '0;
    bit mon_on = 0, rand_wr = 0;

    // Flash model: streams pattern bytes from the start address while keep_reading is high,
    // and sprinkles junk strobes at other times that the fetcher must ignore.
    logic [23:0] cur = '0;
    always @(negedge clk) begin
        if (rst) begin
            fr_data_ready = 1'b0;
            fr_data = '0;
        end else if (fr_start_read) begin
            cur = fr_addr;
            fr_data_ready = 1'b0;
        end else if (fr_keep_reading) begin
            fr_data_ready = ($urandom % 4) != 0;
            if (fr_data_ready) begin
                fr_data = pat(cur);
                cur = cur + 24'd1;
            end
        end else begin
            fr_data_ready = ($urandom % 8) == 0;
            fr_data = 8'($urandom);
        end
        if (rand_wr) word_ready = 1'($urandom);
    end

    // Monitor: sampled mid-cycle, describes what the coming edge does
    bit push, pop;
    always @(negedge clk) begin
        #2;
        if (mon_on) begin
            check("word_valid", word_valid, occ > 0);
            if (fr_start_read) begin
                starts++;
                last_start = fr_addr;
                check("fr_addr", fr_addr, exp_next);
            end
            if (abort) begin
                occ = 0;
                bc = 0;
                expq.delete();
            end else begin
                push = fr_keep_reading && fr_data_ready && bc == 3;
                pop = word_valid && word_ready;
                if (fr_keep_reading && fr_data_ready) bc = (bc + 1) % 4;
                if (pop) begin
                    got_q.push_back(word_data);
                    if (expq.size() == 0) check("pop_unexpected", 1, 0);
                    else check("word", word_data, expq.pop_front());
                end
                if (push) begin
                    check("push_not_full", occ < DEPTH, 1);
                    exp_next = exp_next + 24'd4;
                end
                occ = occ + int'(push) - int'(pop);
                if (req_valid && req_ready) begin
                    exp_next = req_addr & 24'hFFFFFC;
                    for (int i = 0; i < int'(req_words); i++) expq.push_back(word_at(exp_next + 24'(4 * i)));
                end
            end
            if (occ > max_occ) max_occ = occ;
        end
    end

    task automatic send(input logic [23:0] a, input logic [15:0] n);
        int k = 0;
        @(negedge clk);
        while (!req_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) check("req_ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_addr = a;
        req_words = n;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit drain);
        int k = 0;
        while (k < 4000) begin
            @(negedge clk);
            if (!busy && (!drain || (expq.size() == 0 && !word_valid))) break;
            k++;
        end
        if (k >= 4000) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int s0, k;
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_words = '0;
        abort = 1'b0;
        word_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_word_valid", word_valid, 0);
        check("rst_word_data", word_data, 0);
        check("rst_busy", busy, 0);
        check("rst_start", fr_start_read, 0);
        check("rst_keep", fr_keep_reading, 0);
        check("rst_fr_addr", fr_addr, 0);
        rst = 1'b0;
        mon_on = 1;

        word_ready = 1'b1;
        got_q.delete();
        send(24'h4389E1, 2);
        check("t1_start", fr_start_read, 1);
        check("t1_keep_lo", fr_keep_reading, 0);
        check("t1_addr", fr_addr, 24'h4389E0);
        @(negedge clk);
        check("t1_keep_hi", fr_keep_reading, 1);
        check("t1_start_lo", fr_start_read, 0);
        wait_done("t1", 1);
        check("t1_n", got_q.size(), 2);
        check("t1_w0", got_q[0], 32'h29282B2A);
        check("t1_w1", got_q[1], 32'h2D2C2F2E);
        check("t1_busy", busy, 0);

        got_q.delete();
        send(24'hFFFFFC, 2);
        wait_done("t2", 1);
        check("t2_n", got_q.size(), 2);
        check("t2_w0", got_q[0], 32'hFFFEFDFC);
        check("t2_w1", got_q[1], 32'h03020100);

        word_ready = 1'b0;
        got_q.delete();
        s0 = starts;
        send(24'h000000, 8);
        k = 0;
        while (occ != DEPTH && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("t3_fill", occ, DEPTH);
        repeat (4) @(negedge clk);
        check("t3_keep_lo", fr_keep_reading, 0);
        check("t3_busy", busy, 1);
        check("t3_valid", word_valid, 1);
        check("t3_starts1", starts - s0, 1);
        word_ready = 1'b1;
        wait_done("t3", 1);
        check("t3_starts2", starts - s0, 2);
        check("t3_restart", last_start, 24'h000010);
        check("t3_n", got_q.size(), 8);
        check("t3_w4", got_q[4], 32'h13121110);

        word_ready = 1'b0;
        got_q.delete();
        send(24'h000000, 4);
        k = 0;
        while (!(occ == 2 && bc == 2) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("t4_reach", k < 1000, 1);
        abort = 1'b1;
        check("t4_req_ready_abort", req_ready, 0);
        @(negedge clk);
        abort = 1'b0;
        check("t4_valid", word_valid, 0);
        check("t4_busy", busy, 0);
        check("t4_keep", fr_keep_reading, 0);
        word_ready = 1'b1;
        send(24'h000040, 1);
        wait_done("t4", 1);
        check("t4_n", got_q.size(), 1);
        check("t4_w", got_q[0], 32'h43424140);

        s0 = starts;
        send(24'h000100, 0);
        check("t5_req_ready", req_ready, 1);
        repeat (5) @(negedge clk);
        check("t5_starts", starts - s0, 0);
        check("t5_busy", busy, 0);
        check("t5_req_ready2", req_ready, 1);

        got_q.delete();
        s0 = starts;
        max_occ = 0;
        send(24'hFFFFE0, 16'h0110);
        wait_done("t6", 1);
        check("t6_n", got_q.size(), 32'h110);
        check("t6_max_occ", max_occ, 1);
        check("t6_starts", starts - s0, 1);

        rand_wr = 1;
        for (int r = 0; r < 20; r++) begin
            send(24'($urandom), 16'($urandom_range(0, 12)));
            if ($urandom % 4 == 0) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
            wait_done("rand", 0);
        end
        wait_done("rand_drain", 1);
        rand_wr = 0;
        check("rand_empty", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
